// File: rtl/cfg_frame_assembler_if.sv
// rtl/cfg_frame_assembler_if.sv - beat, header and body-FIFO signal bundle for cfg_frame_assembler
interface cfg_frame_assembler_if #(
  parameter int DATA_W     = 128,
  parameter int HDR_BEATS  = 4,
  parameter int FIFO_DEPTH = 16
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0]           I_cfg_data;
  logic                        I_cfg_valid;
  logic                        O_cfg_ready;
  logic                        I_frame_done;
  logic [DATA_W*HDR_BEATS-1:0] O_hdr_value;
  logic                        O_hdr_valid;
  logic                        O_hdr_err;
  logic [DATA_W-1:0]           O_body_data;
  logic                        O_body_valid;
  logic                        I_body_ready;
  logic [AW:0]                 O_fifo_level;
  logic [15:0]                 O_body_cnt;

  // Assembler side
  modport slave (
    input  I_cfg_data, I_cfg_valid, I_frame_done, I_body_ready,
    output O_cfg_ready, O_hdr_value, O_hdr_valid, O_hdr_err,
           O_body_data, O_body_valid, O_fifo_level, O_body_cnt
  );

  // Producer/consumer side
  modport master (
    output I_cfg_data, I_cfg_valid, I_frame_done, I_body_ready,
    input  O_cfg_ready, O_hdr_value, O_hdr_valid, O_hdr_err,
           O_body_data, O_body_valid, O_fifo_level, O_body_cnt
  );
endinterface

// File: rtl/cfg_frame_assembler.sv
// rtl/cfg_frame_assembler.sv - config frame assembler: header packer plus FWFT body FIFO (optional CFG_FRAME_HDR_CHECK_EN)
module cfg_frame_assembler #(
  parameter int DATA_W     = 128,
  parameter int HDR_BEATS  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  I_sys_clk,
  input  logic                  I_sys_rst_n,
  cfg_frame_assembler_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = DATA_W * HDR_BEATS;
  localparam int CW = $clog2(HDR_BEATS + 1);

  typedef enum logic {S_HDR, S_BODY} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     hdr_cnt;
  logic [HW-1:0]     hdr_value;
  logic [HW-1:0]     hdr_shift;
  logic              hdr_valid;
  logic              hdr_last;
  logic              hdr_ok;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic [15:0]       body_cnt;
  logic              full, ready, accept, push, pop;

  // Next-state decode, handshake qualifiers and the header shift/check
  always_comb begin
    state_next = state;
    full       = (level == (AW+1)'(FIFO_DEPTH));
    ready      = (state == S_HDR) || !full;
    accept     = bus.I_cfg_valid && ready;
    // First beat migrates toward the MS slice as later beats shift in below it
    hdr_shift  = (hdr_value << DATA_W) | HW'(bus.I_cfg_data);
    hdr_last   = (state == S_HDR) && accept && (hdr_cnt == CW'(HDR_BEATS - 1));
`ifdef CFG_FRAME_HDR_CHECK_EN
    hdr_ok     = (hdr_shift[HW-1 -: 8] == 8'hA5);
`else
    hdr_ok     = 1'b1;
`endif
    push       = (state == S_BODY) && accept && !bus.I_frame_done;
    pop        = (level != '0) && bus.I_body_ready && !bus.I_frame_done;
    if (bus.I_frame_done) begin
      state_next = S_HDR;
    end else if (hdr_last && hdr_ok) begin
      state_next = S_BODY;
    end
  end

  // State register
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n) begin
      state <= S_HDR;
    end else begin
      state <= state_next;
    end
  end

  // Header packing, FIFO bookkeeping and body count; frame_done flushes like reset
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n || bus.I_frame_done) begin
      hdr_cnt   <= '0;
      hdr_value <= '0;
      hdr_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      body_cnt  <= '0;
    end else begin
      hdr_valid <= 1'b0;
      if ((state == S_HDR) && accept) begin
        if (hdr_last) begin
          hdr_cnt   <= '0;
          hdr_value <= hdr_ok ? hdr_shift : '0;
          hdr_valid <= hdr_ok;
        end else begin
          hdr_cnt   <= hdr_cnt + CW'(1);
          hdr_value <= hdr_shift;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (body_cnt != 16'hFFFF) begin
          body_cnt <= body_cnt + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Body storage; contents need no reset because level gates visibility
  always_ff @(posedge I_sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.I_cfg_data;
    end
  end

`ifdef CFG_FRAME_HDR_CHECK_EN
  logic hdr_err;

  // One-cycle pulse when a completed header fails the marker check
  always_ff @(posedge I_sys_clk) begin
    if (!I_sys_rst_n || bus.I_frame_done) begin
      hdr_err <= 1'b0;
    end else begin
      hdr_err <= hdr_last && !hdr_ok;
    end
  end

  assign bus.O_hdr_err = hdr_err;
`else
  assign bus.O_hdr_err = 1'b0;
`endif

  assign bus.O_cfg_ready  = ready;
  assign bus.O_hdr_value  = hdr_value;
  assign bus.O_hdr_valid  = hdr_valid;
  assign bus.O_body_data  = mem[rd_ptr];
  assign bus.O_body_valid = (level != '0);
  assign bus.O_fifo_level = level;
  assign bus.O_body_cnt   = body_cnt;

endmodule

// File: doc/cfg_frame_assembler.md
Name: cfg_frame_assembler

Overview:
- Single-clock configuration-frame assembler in the system clock domain; parametrised successor of the fixed 4×128-bit header packer.
- Collects HDR_BEATS header beats of DATA_W bits into one wide header word and pulses a valid flag.
- Buffers the following body beats in a FIFO_DEPTH-entry first-word-fall-through FIFO with valid/ready backpressure; nothing is dropped.
- I_frame_done flushes all state and re-arms the block for the next frame.

Parameters:
- DATA_W, 128, width of one config beat.
- HDR_BEATS, 4, header beats per frame (>=1).
- FIFO_DEPTH, 16, body FIFO entries (power of two, >=2); AW = $clog2(FIFO_DEPTH).

Ports:
- I_sys_clk  in  1  system clock.
- I_sys_rst_n  in  1  reset, synchronous, active-low.
- I_cfg_data  in  DATA_W  input beat.
- I_cfg_valid  in  1  input beat valid.
- O_cfg_ready  out  1  input beat accepted when valid&&ready.
- I_frame_done  in  1  end-of-frame; flush and re-arm.
- O_hdr_value  out  DATA_W*HDR_BEATS  assembled header.
- O_hdr_valid  out  1  one-cycle header-complete pulse.
- O_hdr_err  out  1  header check failure pulse (see Optional Feature).
- O_body_data  out  DATA_W  FIFO head.
- O_body_valid  out  1  FIFO not empty.
- I_body_ready  in  1  consumer pop.
- O_fifo_level  out  AW+1  FIFO occupancy, 0..FIFO_DEPTH.
- O_body_cnt  out  16  body beats accepted since last done; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: one clock, I_sys_clk; reset I_sys_rst_n is synchronous and active-low.
- Reset state: state=HDR, header count=0, FIFO pointers=0. O_hdr_value=0, O_hdr_valid=0, O_hdr_err=0, O_body_valid=0, O_fifo_level=0, O_body_cnt=0.
- States: HDR, BODY.
- O_cfg_ready (combinational from registers): 1 in HDR; ~full in BODY. It is 1 after reset.
- HDR state, on each accepted beat:
  - O_hdr_value <= {O_hdr_value[DATA_W*(HDR_BEATS-1)-1:0], I_cfg_data}, so the first beat ends up in the MS slice.
  - Header count increments.
- HDR completion: on acceptance of beat HDR_BEATS, the next edge sets O_hdr_valid=1 for exactly one cycle (O_hdr_value is complete in that cycle), clears the count and moves to BODY.
- O_hdr_value holds its value until I_frame_done or reset.
- BODY state:
  - Accepted beat is written to the FIFO; O_body_cnt increments (saturating).
  - Write-to-O_body_valid latency is 1 cycle; no combinational pass-through.
- Pop: occurs when O_body_valid && I_body_ready. O_body_data always shows the head entry.
  - Simultaneous push and pop leaves the level unchanged.
  - When full, ready=0, so push-on-full cannot happen.
  - Pop on empty is ignored.
- Pointers: AW bits wrap naturally. The level is tracked separately.
- I_frame_done (highest priority, any state): at the next edge:
  - state=HDR, header count=0, O_hdr_value=0, FIFO pointers and level=0, O_body_cnt=0.
  - A beat handshaked in the same cycle is consumed and discarded.
  - A pop in the same cycle is discarded.
  - A header-completion pulse due in the same cycle is suppressed.
- Reset mid-frame has the same effect as I_frame_done, plus all outputs return to their reset values.

Optional Feature:
- Macro: CFG_FRAME_HDR_CHECK_EN.
- Defined:
  - On header completion, check the top byte of the first header beat (O_hdr_value[DATA_W*HDR_BEATS-1 -: 8]) against 8'hA5.
  - Mismatch: O_hdr_err pulses for one cycle instead of O_hdr_valid, O_hdr_value clears to 0, and the state stays HDR.
  - Match: normal behaviour.
- Undefined: O_hdr_err is tied to 0 and no check is made.

Test Plan:
- Reset, then beats 1,2,3,4 with valid held high → O_hdr_valid high for exactly 1 cycle, one cycle after beat 4 is accepted; O_hdr_value[511:384]=1 and [127:0]=4; state BODY.
- After the header, 20 body beats 0x10..0x23 with I_body_ready=0 → 16 accepted; O_cfg_ready=0 after the 16th; O_fifo_level=16. Then I_body_ready=1 → 0x10..0x23 emerge in order; O_body_cnt=20.
- Level 8, valid and I_body_ready both high for 10 cycles → level stays 8, data order preserved, O_body_cnt +10.
- Level 5 in BODY, I_frame_done pulse → next cycle O_fifo_level=0, O_body_valid=0, O_hdr_value=0, O_body_cnt=0. Next 4 beats form a new header.
- In HDR after 2 beats, I_frame_done asserted with a valid beat in the same cycle → beat discarded. A following 4 beats complete the header, containing none of the earlier beats.
- With CFG_FRAME_HDR_CHECK_EN: first beat top byte 0x5A → O_hdr_err 1-cycle pulse, no O_hdr_valid, state stays HDR. Top byte 0xA5 → O_hdr_valid pulse.
